// File: rtl/sram_arb_pkg.sv
// Shared defaults and enums for the single-port SRAM arbiter and its response buffer.
package sram_arb_pkg;

  localparam int ARB_DATA_W = 64;
  localparam int ARB_DEPTH  = 64;
  localparam int ARB_ADDR_W = $clog2(ARB_DEPTH);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef enum logic {
    RR_RD,
    RR_WR
  } rr_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry FIFO holding read data returned by the macro until the consumer takes it.
module sram_rsp_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   occ,
  output logic         full,
  output logic         empty
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign occ   = occ_q;
  assign full  = (occ_q == 2'd2);
  assign empty = (occ_q == 2'd0);

endmodule

// File: rtl/sram_sp_arbiter.sv
// Shares one single-port SRAM between a writer and a reader; zero-fills the array after reset
// and returns read data in request order through a 2-entry buffer.
module sram_sp_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_W = ARB_DATA_W,
  parameter int DEPTH  = ARB_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RSTB,
  output logic              init_done,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  rr_e               rr_q, rr_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              inflight_q, inflight_d;
  logic              init_done_q, init_done_d;

  logic              grant_wr, grant_rd;
  logic              rd_ok, rsp_pop;
  logic [2:0]        credit_used;
  logic [1:0]        rsp_occ;
  logic              rsp_full, rsp_empty;

  assign rsp_valid = !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;

  // Handshakes: a transfer happens in a cycle where valid and ready are both 1; ready is a
  // same-cycle grant and never waits on anything but arbitration and buffer credit.
  always_comb begin
    credit_used = {1'b0, rsp_occ} + {2'b00, inflight_q} - {2'b00, rsp_pop};
    rd_ok       = rd_valid && (credit_used < 3'd2);
    grant_wr    = 1'b0;
    grant_rd    = 1'b0;
    rr_d        = rr_q;
    if (state_q == ST_RUN) begin
      if (wr_valid && rd_ok) begin
        grant_rd = (rr_q == RR_RD);
        grant_wr = (rr_q == RR_WR);
        rr_d     = (rr_q == RR_RD) ? RR_WR : RR_RD;
      end else if (wr_valid) begin
        grant_wr = 1'b1;
      end else if (rd_ok) begin
        grant_rd = 1'b1;
      end
    end
  end

  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (state_q == ST_INIT) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = init_cnt_q;
    end else if (grant_wr) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = wr_addr;
      sram_d   = wr_data;
    end else if (grant_rd) begin
      sram_ceb = 1'b0;
      sram_a   = rd_addr;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end
    end
    inflight_d  = grant_rd;
    init_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q     <= ST_INIT;
      rr_q        <= RR_RD;
      init_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      init_cnt_q  <= init_cnt_d;
      inflight_q  <= inflight_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_done = init_done_q;
  assign wr_ready  = grant_wr;
  assign rd_ready  = grant_rd;

  // Macro data is valid only in the cycle after the read, which is exactly when inflight_q is set.
  sram_rsp_fifo #(.W(DATA_W)) u_rsp_fifo (
    .clk   (CLK),
    .rst_n (RSTB),
    .push  (inflight_q),
    .din   (sram_q),
    .pop   (rsp_pop),
    .dout  (rsp_data),
    .occ   (rsp_occ),
    .full  (rsp_full),
    .empty (rsp_empty)
  );

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTB) !(inflight_q && rsp_full));

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Bench for sram_sp_arbiter: behavioural single-port macro, reference memory and response scoreboard.
module tb_sram_sp_arbiter;

  localparam int DW    = 64;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          CLK = 1'b0;
  logic          RSTB = 1'b0;
  logic          init_done;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          sram_ceb;
  logic          sram_web;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  int dual_grants = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem[DEPTH];

  logic [DW-1:0] sram_mem[DEPTH];
  bit            seeded = 1'b0;

  sram_sp_arbiter dut (
    .CLK       (CLK),
    .RSTB      (RSTB),
    .init_done (init_done),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .sram_ceb  (sram_ceb),
    .sram_web  (sram_web),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // Macro model: contents power up random; q is garbage except the cycle after a read.
  always @(posedge CLK) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] <= {$urandom, $urandom};
      seeded <= 1'b1;
      sram_q <= {$urandom, $urandom};
    end else begin
      if (!sram_ceb && !sram_web) sram_mem[sram_a] <= sram_d;
      if (!sram_ceb && sram_web) sram_q <= sram_mem[sram_a];
      else sram_q <= {$urandom, $urandom};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic sb_monitor();
    logic [DW-1:0] exp;
    forever begin
      @(negedge CLK);
      if (RSTB === 1'b1) begin
        if (wr_ready === 1'b1 && rd_ready === 1'b1) dual_grants++;
        if (wr_valid && wr_ready === 1'b1) ref_mem[wr_addr] = wr_data;
        if (rd_valid && rd_ready === 1'b1) exp_q.push_back(ref_mem[rd_addr]);
        if (rsp_valid === 1'b1 && rsp_ready) begin
          checks++;
          rsp_cnt++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got rsp_data=%h, required no response", rsp_data);
          end else begin
            exp = exp_q.pop_front();
            if (rsp_data !== exp) begin
              errors++;
              $display("FAIL rsp_data: got %h, required %h", rsp_data, exp);
            end
          end
        end
      end
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (rd_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic check_init();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    wr_addr  = AW'(3);
    rd_addr  = AW'(4);
    wr_data  = {$urandom, $urandom};
    for (int c = 0; c < DEPTH; c++) begin
      @(negedge CLK);
      checks++;
      if (sram_ceb !== 1'b0 || sram_web !== 1'b0 || sram_a !== AW'(c) || sram_d !== '0 ||
          wr_ready !== 1'b0 || rd_ready !== 1'b0 || init_done !== 1'b0) begin
        errors++;
        $display("FAIL init_write c%0d: ceb=%b web=%b a=%0d d=%h wrdy=%b rrdy=%b done=%b, required 0 0 %0d 0 0 0 0",
                 c, sram_ceb, sram_web, sram_a, sram_d, wr_ready, rd_ready, init_done, c);
      end
    end
    @(posedge CLK);
    #1;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (init_done !== 1'b1 || sram_ceb !== 1'b1) begin
      errors++;
      $display("FAIL init_done_rise: got done=%b ceb=%b, required done=1 ceb=1", init_done, sram_ceb);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RSTB = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (init_done !== 1'b0 || wr_ready !== 1'b0 || rd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b wrdy=%b rrdy=%b rspv=%b, required all 0",
               init_done, wr_ready, rd_ready, rsp_valid);
    end
    @(posedge CLK);
    #1;
    RSTB = 1'b1;
    check_init();
  endtask

  task automatic test_read_zero(input logic [AW-1:0] addr);
    bit ok;
    @(posedge CLK);
    #1;
    rsp_ready = 1'b1;
    rd_valid  = 1'b1;
    rd_addr   = addr;
    wait_rd(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL read_grant_timeout: got rd_ready=0, required 1 within 20 cycles");
    end
    @(posedge CLK);
    #1;
    rd_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_latency_t1: got rsp_valid=%b, required 0", rsp_valid);
    end
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== '0) begin
      errors++;
      $display("FAIL read_zero_t2: got rsp_valid=%b data=%h, required 1 and 0", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    d = 64'hDEAD_BEEF_0000_0011;
    @(posedge CLK);
    #1;
    wr_valid = 1'b1;
    wr_addr  = AW'(7);
    wr_data  = d;
    @(negedge CLK);
    checks++;
    if (wr_ready !== 1'b1 || sram_ceb !== 1'b0 || sram_web !== 1'b0 || sram_a !== AW'(7) || sram_d !== d) begin
      errors++;
      $display("FAIL write_grant: got wrdy=%b ceb=%b web=%b a=%0d d=%h, required 1 0 0 7 %h",
               wr_ready, sram_ceb, sram_web, sram_a, sram_d, d);
    end
    @(posedge CLK);
    #1;
    wr_valid = 1'b0;
    rd_valid = 1'b1;
    rd_addr  = AW'(7);
    @(negedge CLK);
    checks++;
    if (rd_ready !== 1'b1 || sram_web !== 1'b1 || sram_a !== AW'(7)) begin
      errors++;
      $display("FAIL read_after_write_grant: got rrdy=%b web=%b a=%0d, required 1 1 7", rd_ready, sram_web, sram_a);
    end
    @(posedge CLK);
    #1;
    rd_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== d) begin
      errors++;
      $display("FAIL read_after_write_data: got rsp_valid=%b data=%h, required 1 %h", rsp_valid, rsp_data, d);
    end
  endtask

  task automatic test_arbitration();
    logic [AW-1:0] ra[2];
    logic [AW-1:0] wa[2];
    logic [DW-1:0] wd[2];
    int ri, wi;
    bit exp_rd;
    logic [AW-1:0] exp_a;
    ra[0] = AW'(21); ra[1] = AW'(20);
    wa[0] = AW'(20); wa[1] = AW'(21);
    wd[0] = {$urandom, $urandom}; wd[1] = {$urandom, $urandom};
    ri = 0;
    wi = 0;
    @(posedge CLK);
    #1;
    rsp_ready = 1'b1;
    rd_valid  = 1'b1;
    wr_valid  = 1'b1;
    rd_addr   = ra[0];
    wr_addr   = wa[0];
    wr_data   = wd[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      exp_rd = ((k % 2) == 0);
      exp_a  = exp_rd ? ra[ri % 2] : wa[wi % 2];
      checks++;
      if (rd_ready !== exp_rd || wr_ready !== !exp_rd || sram_ceb !== 1'b0 ||
          sram_web !== exp_rd || sram_a !== exp_a) begin
        errors++;
        $display("FAIL arb_cycle%0d: got rrdy=%b wrdy=%b ceb=%b web=%b a=%0d, required rrdy=%b wrdy=%b ceb=0 web=%b a=%0d",
                 k, rd_ready, wr_ready, sram_ceb, sram_web, sram_a, exp_rd, !exp_rd, exp_rd, exp_a);
      end
      if (exp_rd) ri++;
      else wi++;
      @(posedge CLK);
      #1;
      rd_addr = ra[ri % 2];
      wr_addr = wa[wi % 2];
      wr_data = wd[wi % 2];
    end
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (dual_grants != 0) begin
      errors++;
      $display("FAIL dual_grant: got %0d cycles with both readies, required 0", dual_grants);
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a[4];
    logic [5:0]    pat;
    logic [DW-1:0] held;
    int issued, cnt0;
    a[0] = AW'(7); a[1] = AW'(20); a[2] = AW'(21); a[3] = AW'(5);
    pat = 6'b000011;
    issued = 0;
    held = '0;
    cnt0 = rsp_cnt;
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    rd_valid  = 1'b1;
    rd_addr   = a[0];
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      checks++;
      if (rd_ready !== pat[k]) begin
        errors++;
        $display("FAIL bp_credit_c%0d: got rd_ready=%b, required %b", k, rd_ready, pat[k]);
      end
      if (pat[k]) issued++;
      if (k == 3) held = rsp_data;
      if (k == 5) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== held) begin
          errors++;
          $display("FAIL bp_hold: got rsp_valid=%b data=%h, required 1 %h", rsp_valid, rsp_data, held);
        end
      end
      @(posedge CLK);
      #1;
      rd_addr = a[issued];
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (rd_ready === 1'b1) issued++;
      @(posedge CLK);
      #1;
      if (issued >= 4) break;
      rd_addr = a[issued];
    end
    rd_valid = 1'b0;
    checks++;
    if (issued != 4) begin
      errors++;
      $display("FAIL bp_issue: got %0d reads granted, required 4", issued);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (rsp_cnt - cnt0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d responses, %0d pending, required 4 and 0", rsp_cnt - cnt0, exp_q.size());
    end
  endtask

  task automatic test_random();
    bit wg, rg;
    wg = 1'b0;
    rg = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge CLK);
      #1;
      if (!wr_valid || wg) begin
        wr_valid = 1'($urandom_range(0, 1));
        wr_addr  = AW'($urandom_range(0, 15));
        wr_data  = {$urandom, $urandom};
      end
      if (!rd_valid || rg) begin
        rd_valid = 1'($urandom_range(0, 1));
        rd_addr  = AW'($urandom_range(0, 15));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      wg = (wr_ready === 1'b1);
      rg = (rd_ready === 1'b1);
    end
    @(posedge CLK);
    #1;
    wr_valid  = 1'b0;
    rd_valid  = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0 || rsp_valid !== 1'b0 || dual_grants != 0) begin
      errors++;
      $display("FAIL random_drain: got pending=%0d rsp_valid=%b dual=%0d, required 0 0 0",
               exp_q.size(), rsp_valid, dual_grants);
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    rd_valid  = 1'b1;
    rd_addr   = AW'(7);
    wait_rd(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midflight_grant_timeout: got rd_ready=0, required 1 within 20 cycles");
    end
    @(posedge CLK);
    #1;
    rd_addr = AW'(5);
    @(negedge CLK);
    @(posedge CLK);
    #1;
    rd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL midflight_pre: got rsp_valid=%b, required 1", rsp_valid);
    end
    RSTB = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || init_done !== 1'b0 || rd_ready !== 1'b0) begin
      errors++;
      $display("FAIL midflight_reset: got rsp_valid=%b done=%b rrdy=%b, required 0 0 0",
               rsp_valid, init_done, rd_ready);
    end
    rsp_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RSTB = 1'b1;
    check_init();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    fork
      sb_monitor();
    join_none
    test_reset();
    test_read_zero(AW'(5));
    test_write_read();
    test_arbitration();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_read_zero(AW'(7));
    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
